// File: rtl/bus_arbiter_pkg.sv
// Shared types and default address map for the CPU/OAM-DMA bus arbiter.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_XFER  = 2'd2
    } dma_state_e;

    typedef struct packed {
        dma_state_e state;
        logic [1:0] phase;
    } dma_dbg_t;

    localparam logic [15:0] DEF_DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] DEF_OAM_BASE     = 16'hFE00;
    localparam int          DEF_DMA_LEN      = 160;
    localparam logic [15:0] DEF_HRAM_LO      = 16'hFF80;
    localparam logic [15:0] DEF_HRAM_HI      = 16'hFFFE;

    // Pages E0..FF mirror C0..DF, so the source is folded down by 0x20.
    function automatic logic [7:0] dma_src_hi(input logic [7:0] reg_val);
        return (reg_val >= 8'hE0) ? (reg_val - 8'h20) : reg_val;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Memory-side bus: a requester (master) issues reads/writes, memory (slave) returns read data one clock later.
interface bus_arbiter_if;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;

    modport master (output rd_addr, wr_en, wr_addr, wr_data, input rd_data);
    modport slave  (input rd_addr, wr_en, wr_addr, wr_data, output rd_data);
endinterface

// File: rtl/bus_arbiter_oam_dma_engine.sv
// OAM DMA sequencer: 4-clock start delay, then one byte per 4-clock slot (read T0, latch T1, write T2, advance T3).
module oam_dma_engine
    import bus_arbiter_pkg::*;
#(
    parameter logic [15:0] OAM_BASE = DEF_OAM_BASE,
    parameter int          DMA_LEN  = DEF_DMA_LEN
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [7:0]    i_start_val,
    output logic [7:0]    o_dma_reg,
    output logic          o_active,
    output dma_dbg_t      o_dbg,
    bus_arbiter_if.master bus
);

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    dma_state_e state_q;
    logic [1:0] phase_q;
    logic [7:0] idx_q;
    logic [7:0] byte_q;
    logic [7:0] dma_reg_q;
    logic       active_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            phase_q   <= 2'd0;
            idx_q     <= 8'd0;
            byte_q    <= 8'd0;
            dma_reg_q <= 8'd0;
            active_q  <= 1'b0;
        end else if (i_start) begin
            // A register write always (re)starts from byte 0, even mid-transfer.
            dma_reg_q <= i_start_val;
            state_q   <= ST_START;
            phase_q   <= 2'd0;
            idx_q     <= 8'd0;
            active_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_START: begin
                    phase_q <= phase_q + 2'd1;
                    if (phase_q == 2'd3) state_q <= ST_XFER;
                end
                ST_XFER: begin
                    phase_q <= phase_q + 2'd1;
                    if (phase_q == 2'd1) byte_q <= bus.rd_data;
                    if (phase_q == 2'd3) begin
                        if (idx_q == LAST_IDX) begin
                            state_q  <= ST_IDLE;
                            idx_q    <= 8'd0;
                            active_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 8'd1;
                        end
                    end
                end
                default: phase_q <= 2'd0;
            endcase
        end
    end

    assign bus.rd_addr = {dma_src_hi(dma_reg_q), idx_q};
    assign bus.wr_en   = (state_q == ST_XFER) && (phase_q == 2'd2);
    assign bus.wr_addr = OAM_BASE + {8'h00, idx_q};
    assign bus.wr_data = byte_q;

    assign o_dma_reg = dma_reg_q;
    assign o_active  = active_q;
    assign o_dbg     = '{state: state_q, phase: phase_q};

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates one memory port between the CPU and the OAM DMA engine; CPU sees only HRAM while DMA runs.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = DEF_DMA_REG_ADDR,
    parameter logic [15:0] OAM_BASE     = DEF_OAM_BASE,
    parameter int          DMA_LEN      = DEF_DMA_LEN,
    parameter logic [15:0] HRAM_LO      = DEF_HRAM_LO,
    parameter logic [15:0] HRAM_HI      = DEF_HRAM_HI
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_cpu_rd_addr,
    output logic [7:0]  o_cpu_rd_data,
    input  logic        i_cpu_wr_en,
    input  logic [15:0] i_cpu_wr_addr,
    input  logic [7:0]  i_cpu_wr_data,
    output logic [15:0] o_mem_rd_addr,
    input  logic [7:0]  i_mem_rd_data,
    output logic        o_mem_wr_en,
    output logic [15:0] o_mem_wr_addr,
    output logic [7:0]  o_mem_wr_data,
    output logic        o_dma_active
);

    bus_arbiter_if dma_bus ();

    dma_dbg_t   dbg;
    logic [7:0] dma_reg;
    logic       active;

    logic dma_reg_wr, hram_wr, hram_rd, cpu_wr_ok, dma_rd_slot;
    logic grant_q, grant_d;
    logic [7:0] hold_q, hold_d;
    logic wbuf_v_q, wbuf_v_d;
    logic [15:0] wbuf_a_q, wbuf_a_d;
    logic [7:0] wbuf_d_q, wbuf_d_d;
    logic mem_wr_en;

    assign dma_reg_wr = i_cpu_wr_en && (i_cpu_wr_addr == DMA_REG_ADDR);
    assign hram_wr    = (i_cpu_wr_addr >= HRAM_LO) && (i_cpu_wr_addr <= HRAM_HI);
    assign hram_rd    = (i_cpu_rd_addr >= HRAM_LO) && (i_cpu_rd_addr <= HRAM_HI);
    assign cpu_wr_ok  = i_cpu_wr_en && (!active || hram_wr || dma_reg_wr);

    oam_dma_engine #(
        .OAM_BASE (OAM_BASE),
        .DMA_LEN  (DMA_LEN)
    ) u_engine (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (dma_reg_wr),
        .i_start_val (i_cpu_wr_data),
        .o_dma_reg   (dma_reg),
        .o_active    (active),
        .o_dbg       (dbg),
        .bus         (dma_bus)
    );

    assign dma_rd_slot     = (dbg.state == ST_XFER) && (dbg.phase == 2'd0);
    assign o_mem_rd_addr   = dma_rd_slot ? dma_bus.rd_addr : i_cpu_rd_addr;
    assign dma_bus.rd_data = i_mem_rd_data;
    assign o_dma_active    = active;

    // Memory answers one clock late, so the hold register samples in the clock after a CPU grant.
    assign grant_d = !dma_rd_slot;
    assign hold_d  = grant_q ? i_mem_rd_data : hold_q;

    always_comb begin
        if (i_cpu_rd_addr == DMA_REG_ADDR) o_cpu_rd_data = dma_reg;
        else if (!active)                  o_cpu_rd_data = i_mem_rd_data;
        else if (!hram_rd)                 o_cpu_rd_data = 8'hFF;
        else                               o_cpu_rd_data = hold_q;
    end

    // Write port priority: DMA T2, then a buffered CPU write, then the live CPU write.
    always_comb begin
        mem_wr_en     = 1'b0;
        o_mem_wr_addr = i_cpu_wr_addr;
        o_mem_wr_data = i_cpu_wr_data;
        wbuf_v_d      = 1'b0;
        wbuf_a_d      = wbuf_a_q;
        wbuf_d_d      = wbuf_d_q;
        if (dma_bus.wr_en) begin
            mem_wr_en     = 1'b1;
            o_mem_wr_addr = dma_bus.wr_addr;
            o_mem_wr_data = dma_bus.wr_data;
        end else if (wbuf_v_q) begin
            mem_wr_en     = 1'b1;
            o_mem_wr_addr = wbuf_a_q;
            o_mem_wr_data = wbuf_d_q;
        end else if (cpu_wr_ok) begin
            mem_wr_en = 1'b1;
        end
        if (cpu_wr_ok && (dma_bus.wr_en || wbuf_v_q)) begin
            wbuf_v_d = 1'b1;
            wbuf_a_d = i_cpu_wr_addr;
            wbuf_d_d = i_cpu_wr_data;
        end
    end

    assign o_mem_wr_en = mem_wr_en && !i_rst;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            grant_q  <= 1'b0;
            hold_q   <= 8'd0;
            wbuf_v_q <= 1'b0;
            wbuf_a_q <= 16'd0;
            wbuf_d_q <= 8'd0;
        end else begin
            grant_q  <= grant_d;
            hold_q   <= hold_d;
            wbuf_v_q <= wbuf_v_d;
            wbuf_a_q <= wbuf_a_d;
            wbuf_d_q <= wbuf_d_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: cycle-count model of the DMA timeline plus directed literal checks.
module tb_bus_arbiter;

    localparam int XFER_CLKS = 644;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cpu_rd_addr = 16'h0000;
    logic [7:0]  cpu_rd_data;
    logic        cpu_wr_en = 1'b0;
    logic [15:0] cpu_wr_addr = 16'h0000;
    logic [7:0]  cpu_wr_data = 8'h00;
    logic        dma_active;

    bus_arbiter_if mem_bus ();

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];

    int n_checks = 0;
    int n_fail   = 0;

    string       name_q[$];
    logic [15:0] act_q[$];
    logic [15:0] exp_q[$];

    // ---------------- clock / DUT / memory ----------------
    always #5 clk = ~clk;

    bus_arbiter dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cpu_rd_addr (cpu_rd_addr),
        .o_cpu_rd_data (cpu_rd_data),
        .i_cpu_wr_en   (cpu_wr_en),
        .i_cpu_wr_addr (cpu_wr_addr),
        .i_cpu_wr_data (cpu_wr_data),
        .o_mem_rd_addr (mem_bus.rd_addr),
        .i_mem_rd_data (mem_bus.rd_data),
        .o_mem_wr_en   (mem_bus.wr_en),
        .o_mem_wr_addr (mem_bus.wr_addr),
        .o_mem_wr_data (mem_bus.wr_data),
        .o_dma_active  (dma_active)
    );

    always @(posedge clk) begin
        mem_bus.rd_data <= mem[mem_bus.rd_addr];
        if (mem_bus.wr_en) mem[mem_bus.wr_addr] <= mem_bus.wr_data;
    end

    // ---------------- behavioural model ----------------
    // m_t counts clocks since the last trigger write: 1..4 start delay, then byte k owns clocks 5+4k..8+4k.
    int          m_t = 0;
    logic [7:0]  m_dma = 8'h00;
    logic        m_pend_v = 1'b0;
    logic [15:0] m_pend_a = 16'h0000;
    logic [7:0]  m_pend_d = 8'h00;

    function automatic logic [7:0] src_hi(input logic [7:0] r);
        if (r >= 8'hE0) return r - 8'h20;
        return r;
    endfunction

    function automatic logic [15:0] m_rd_addr();
        if (m_t >= 5 && ((m_t - 5) % 4) == 0) return {src_hi(m_dma), 8'((m_t - 5) / 4)};
        return cpu_rd_addr;
    endfunction

    function automatic void m_expect(output logic wv, output logic [15:0] wa, output logic [7:0] wd,
                                     output logic nv, output logic [15:0] na, output logic [7:0] nd);
        bit act, hram, allowed, dma_wr;
        int k;
        act     = (m_t != 0);
        k       = (m_t - 5) / 4;
        dma_wr  = act && (m_t >= 5) && (((m_t - 5) % 4) == 2);
        hram    = (cpu_wr_addr >= 16'hFF80) && (cpu_wr_addr <= 16'hFFFE);
        allowed = cpu_wr_en && (!act || hram || cpu_wr_addr == 16'hFF46);
        wv = 1'b0; wa = 16'h0000; wd = 8'h00;
        nv = 1'b0; na = cpu_wr_addr; nd = cpu_wr_data;
        if (dma_wr) begin
            wv = 1'b1;
            wa = 16'hFE00 + 16'(k);
            wd = ref_mem[{src_hi(m_dma), 8'(k)}];
            nv = allowed;
        end else if (m_pend_v) begin
            wv = 1'b1; wa = m_pend_a; wd = m_pend_d;
            nv = allowed;
        end else if (allowed) begin
            wv = 1'b1; wa = cpu_wr_addr; wd = cpu_wr_data;
        end
    endfunction

    logic        mx_wv, mx_nv;
    logic [15:0] mx_wa, mx_na;
    logic [7:0]  mx_wd, mx_nd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t      <= 0;
            m_dma    <= 8'h00;
            m_pend_v <= 1'b0;
        end else begin
            m_expect(mx_wv, mx_wa, mx_wd, mx_nv, mx_na, mx_nd);
            if (mx_wv) ref_mem[mx_wa] <= mx_wd;
            m_pend_v <= mx_nv;
            m_pend_a <= mx_na;
            m_pend_d <= mx_nd;
            if (cpu_wr_en && cpu_wr_addr == 16'hFF46) begin
                m_dma <= cpu_wr_data;
                m_t   <= 1;
            end else if (m_t != 0 && m_t < XFER_CLKS) begin
                m_t <= m_t + 1;
            end else begin
                m_t <= 0;
            end
        end
    end

    // ---------------- scoreboard / compare process ----------------
    function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    logic        cx_wv, cx_nv;
    logic [15:0] cx_wa, cx_na;
    logic [7:0]  cx_wd, cx_nd;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_dma_active", {15'd0, dma_active}, 16'd0);
            check("rst_mem_wr_en", {15'd0, mem_bus.wr_en}, 16'd0);
        end else begin
            m_expect(cx_wv, cx_wa, cx_wd, cx_nv, cx_na, cx_nd);
            check("dma_active", {15'd0, dma_active}, {15'd0, m_t != 0});
            check("mem_wr_en", {15'd0, mem_bus.wr_en}, {15'd0, cx_wv});
            if (cx_wv) begin
                check("mem_wr_addr", mem_bus.wr_addr, cx_wa);
                check("mem_wr_data", {8'd0, mem_bus.wr_data}, {8'd0, cx_wd});
            end
            check("mem_rd_addr", mem_bus.rd_addr, m_rd_addr());
            if (cpu_rd_addr == 16'hFF46)
                check("cpu_rd_dma_reg", {8'd0, cpu_rd_data}, {8'd0, m_dma});
            else if (m_t == 0)
                check("cpu_rd_idle", {8'd0, cpu_rd_data}, {8'd0, mem_bus.rd_data});
            else if (cpu_rd_addr < 16'hFF80 || cpu_rd_addr > 16'hFFFE)
                check("cpu_rd_blocked", {8'd0, cpu_rd_data}, 16'h00FF);
        end
        while (name_q.size() > 0)
            check(name_q.pop_front(), act_q.pop_front(), exp_q.pop_front());
    end

    // ---------------- driver tasks ----------------
    task automatic expect_eq(input string name, input logic [15:0] act, input logic [15:0] exp);
        name_q.push_back(name);
        act_q.push_back(act);
        exp_q.push_back(exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_wr_en   = 1'b1;
        cpu_wr_addr = a;
        cpu_wr_data = d;
        tick();
        cpu_wr_en   = 1'b0;
    endtask

    task automatic wait_t(input int target);
        int n;
        n = 0;
        while (m_t != target && n < 3000) begin
            tick();
            n++;
        end
        if (m_t != target) expect_eq("wait_t_timeout", 16'(m_t), 16'(target));
    endtask

    task automatic measure_active(input string name);
        int n;
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!dma_active) break;
            n++;
        end
        expect_eq(name, 16'(n), 16'(XFER_CLKS));
        tick();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[16'hC100 + 16'(i)]     <= 8'(i);
            ref_mem[16'hC100 + 16'(i)] <= 8'(i);
            mem[16'hC200 + 16'(i)]     <= 8'(255 - i);
            ref_mem[16'hC200 + 16'(i)] <= 8'(255 - i);
            mem[16'hD000 + 16'(i)]     <= 8'(i * 3 + 1);
            ref_mem[16'hD000 + 16'(i)] <= 8'(i * 3 + 1);
        end
        mem[16'hC000] <= 8'h11; ref_mem[16'hC000] <= 8'h11;
        mem[16'hFF90] <= 8'h5A; ref_mem[16'hFF90] <= 8'h5A;

        rst = 1'b1;
        tick(); tick(); tick();
        @(negedge clk);
        expect_eq("reset_active", {15'd0, dma_active}, 16'd0);
        expect_eq("reset_wr_en", {15'd0, mem_bus.wr_en}, 16'd0);
        tick();
        rst = 1'b0;
        tick();

        cpu_rd_addr = 16'hFF46;
        @(negedge clk);
        expect_eq("reset_dma_reg", {8'd0, cpu_rd_data}, 16'h0000);
        tick();
        cpu_rd_addr = 16'hFF90;
        tick(); tick();
        @(negedge clk);
        expect_eq("idle_rd_ff90", {8'd0, cpu_rd_data}, 16'h005A);
        tick();
        cpu_write(16'hC005, 8'h77);
        tick();
        expect_eq("idle_wr_c005", {8'd0, mem[16'hC005]}, 16'h0077);

        // Transfer from page C1
        cpu_write(16'hFF46, 8'hC1);
        measure_active("dur_c1");
        tick(); tick();
        for (int i = 0; i < 160; i++)
            expect_eq("oam_c1", {8'd0, mem[16'hFE00 + 16'(i)]}, 16'(i));
        expect_eq("fwd_ff46", {8'd0, mem[16'hFF46]}, 16'h00C1);

        // Page E2 folds to C2
        cpu_write(16'hFF46, 8'hE2);
        wait_t(5);
        @(negedge clk);
        expect_eq("src_first_e2", mem_bus.rd_addr, 16'hC200);
        tick();
        wait_t(641);
        @(negedge clk);
        expect_eq("src_last_e2", mem_bus.rd_addr, 16'hC29F);
        tick();
        wait_t(0);
        tick(); tick();
        for (int i = 0; i < 160; i++)
            expect_eq("oam_e2", {8'd0, mem[16'hFE00 + 16'(i)]}, 16'(255 - i));

        // CPU access while DMA runs
        cpu_write(16'hFF46, 8'hC1);
        wait_t(6);
        cpu_write(16'hC000, 8'h99);
        wait_t(11);
        cpu_write(16'hFF85, 8'h33);
        @(negedge clk);
        expect_eq("buf_wr_en", {15'd0, mem_bus.wr_en}, 16'd1);
        expect_eq("buf_wr_addr", mem_bus.wr_addr, 16'hFF85);
        expect_eq("buf_wr_data", {8'd0, mem_bus.wr_data}, 16'h0033);
        tick();
        cpu_rd_addr = 16'hC000;
        tick(); tick(); tick();
        @(negedge clk);
        expect_eq("dma_rd_c000", {8'd0, cpu_rd_data}, 16'h00FF);
        tick();
        cpu_rd_addr = 16'hFF90;
        for (int i = 0; i < 8; i++) tick();
        @(negedge clk);
        expect_eq("dma_rd_ff90", {8'd0, cpu_rd_data}, 16'h005A);
        tick();
        cpu_rd_addr = 16'hFF46;
        @(negedge clk);
        expect_eq("dma_rd_ff46", {8'd0, cpu_rd_data}, 16'h00C1);
        tick();
        cpu_rd_addr = 16'h0000;
        wait_t(0);
        tick(); tick();
        expect_eq("dropped_c000", {8'd0, mem[16'hC000]}, 16'h0011);
        expect_eq("hram_ff85", {8'd0, mem[16'hFF85]}, 16'h0033);

        // Restart at idx 50 from page D0
        cpu_write(16'hFF46, 8'hC1);
        wait_t(205);
        cpu_write(16'hFF46, 8'hD0);
        measure_active("dur_restart");
        tick(); tick();
        for (int i = 0; i < 160; i++)
            expect_eq("oam_d0", {8'd0, mem[16'hFE00 + 16'(i)]}, {8'd0, 8'(i * 3 + 1)});

        // Reset at idx 10
        for (int i = 0; i < 160; i++) begin
            mem[16'hFE00 + 16'(i)]     <= 8'hEE;
            ref_mem[16'hFE00 + 16'(i)] <= 8'hEE;
        end
        tick();
        cpu_write(16'hFF46, 8'hC1);
        wait_t(45);
        rst = 1'b1;
        @(negedge clk);
        expect_eq("abort_active", {15'd0, dma_active}, 16'd0);
        expect_eq("abort_wr_en", {15'd0, mem_bus.wr_en}, 16'd0);
        tick(); tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        for (int i = 0; i < 160; i++)
            expect_eq("oam_abort", {8'd0, mem[16'hFE00 + 16'(i)]}, (i < 10) ? 16'(i) : 16'h00EE);
        cpu_rd_addr = 16'hFF46;
        @(negedge clk);
        expect_eq("abort_dma_reg", {8'd0, cpu_rd_data}, 16'h0000);

        tick(); tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
